mips_data_mem_responder: RTL and testbench
==========================================

Name: mips_data_mem_responder

Overview:
- Responder side of the CPU data-memory interface: serves the MEM-stage address, write data and memory-control bus, and returns read data.
- Contains word-addressed data RAM plus a memory-mapped IO page.
- IO page holds a console output FIFO with a valid/ready drain port, a free-running cycle counter, and sticky error flags.
- Read data is combinational so the CPU's MEM/WB register captures it at the same edge.

Parameters:
- ADDR_WIDTH, 8, log2 of RAM depth in 32-bit words (256 words).
- FIFO_DEPTH_LOG2, 3, log2 of console FIFO depth (8 entries).
- IO_PAGE, 16'hFFFF, value of DataAddr[31:16] selecting the IO page.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- DataAddr  input  32  byte address from the CPU MEM stage.
- DataOut  input  32  store data from the CPU.
- MEMReg_s5  input  4  MEM-stage control; bit2 = MemRead, bit1 = MemWrite, bits 3 and 0 ignored.
- DataIn  output  32  load data to the CPU, combinational.
- out_data  output  32  console FIFO head entry.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head entry.
- irq_err  output  1  OR of the sticky error flags.

Behaviour:
- Reset (reset=0, async): FIFO pointers and count = 0; out_valid = 0; out_data = 0; cycle counter = 0; error flags = 0; irq_err = 0. RAM contents are not cleared. Reset mid-transfer discards all FIFO entries immediately.
- Decode: io = (DataAddr[31:16] == IO_PAGE). RAM word index = DataAddr[ADDR_WIDTH+1:2]; upper RAM address bits are ignored, so the RAM aliases.
- Misaligned: DataAddr[1:0] != 0 on any read or write. The access is suppressed (no RAM/IO side effect, DataIn = 0) and err[0] is set at the next edge.
- Write = MEMReg_s5[1]; read = MEMReg_s5[2] & ~MEMReg_s5[1]. If both bits are set, the access is a write and DataIn = 0.
- RAM write: at the rising edge when write & ~io & aligned, RAM[idx] <= DataOut. RAM read: DataIn = RAM[idx] combinationally when read & ~io & aligned; otherwise 0.
- IO map (offset = DataAddr[15:0]):
  - 0x0000 CONSOLE: write pushes DataOut into the FIFO; read returns 0.
  - 0x0004 STATUS (read-only): {24'b0, count[3:0] zero-extended into [7:4], 2'b0, full, empty}; writes are ignored.
  - 0x0008 CYCLE: read returns the counter; write loads DataOut. Counter increments every cycle otherwise and wraps 0xFFFFFFFF -> 0. After a load, the next edge continues from loaded value + 1.
  - 0x000C ERR: read returns {29'b0, err[2:0]}. Write-1-to-clear using DataOut[2:0]. A clear and a set of the same bit in one cycle resolves to set.
  - Any other offset: read returns 0, write ignored; either sets err[2] (unmapped IO).
- FIFO: circular buffer, pointers wrap modulo depth.
  - count = 0..FIFO_DEPTH.
  - out_valid = (count != 0); out_data = entry at read pointer (0 when empty).
  - Pop when out_valid & out_ready. Push on CONSOLE write.
  - Push and pop in the same cycle: both occur and count is unchanged, including when full.
  - Push when full with no pop: data dropped, count unchanged, err[1] set.
  - Pop when empty: no effect.
  - out_data may change only after a pop or when empty->non-empty; it holds stable while out_valid & ~out_ready.
- irq_err = |err, registered (follows the flags at the same edge).
- Latency: RAM/IO reads are 0-cycle combinational. Writes, FIFO, counter and flags update at the rising edge.

Test Plan:
- Reset low, then release; write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> DataIn = 0xDEADBEEF; read 0x00000410 (alias, ADDR_WIDTH=8) -> 0xDEADBEEF.
- Write to 0x00000012 -> RAM word 4 unchanged; err[0] = 1 and irq_err = 1 next cycle; write 0x1 to 0xFFFF000C -> err = 0.
- out_ready=0; push 9 CONSOLE writes 1..9 -> STATUS reads count = 8 with full = 1 (value 0x82); err[1] = 1; out_data = 1. Then out_ready=1 for 8 cycles -> out_data sequence 1..8, then out_valid = 0 and STATUS = 0x01.
- Fill FIFO, then hold out_ready=1 while pushing 0xAA in the same cycle -> count stays 8, err[1] stays 0, 0xAA appears last.
- Write 0xFFFFFFFE to CYCLE -> reads 0xFFFFFFFF one cycle later, then 0x00000000 the cycle after.
- Assert reset mid-drain with 3 entries queued -> out_valid = 0 immediately (asynchronously); RAM word 4 still reads 0xDEADBEEF after reset release.

Source files
------------

// File: rtl/mips_data_mem_responder.sv
`default_nettype none
// ============================================================================
// mips_data_mem_responder : CPU data-memory responder with word RAM and an IO
// page holding a console FIFO, a cycle counter and sticky error flags.
// Revision 1.0
// ============================================================================
module mips_data_mem_responder #(
   parameter int          ADDR_WIDTH      = 8,
   parameter int          FIFO_DEPTH_LOG2 = 3,
   parameter logic [15:0] IO_PAGE         = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DataAddr,
   input  logic [31:0] DataOut,
   input  logic [3:0]  MEMReg_s5,
   output logic [31:0] DataIn,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        irq_err
);

   localparam int c_FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int c_RAM_DEPTH  = 1 << ADDR_WIDTH;

   localparam logic [FIFO_DEPTH_LOG2:0]   c_CNT_FULL = (FIFO_DEPTH_LOG2+1)'(c_FIFO_DEPTH);
   localparam logic [FIFO_DEPTH_LOG2:0]   c_CNT_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] c_PTR_ONE  = FIFO_DEPTH_LOG2'(1);

   localparam logic [15:0] c_OFF_CONSOLE = 16'h0000;
   localparam logic [15:0] c_OFF_STATUS  = 16'h0004;
   localparam logic [15:0] c_OFF_CYCLE   = 16'h0008;
   localparam logic [15:0] c_OFF_ERR     = 16'h000C;

   // storage
   logic [31:0] ram_q  [c_RAM_DEPTH];
   logic [31:0] fifo_q [c_FIFO_DEPTH];

   // state
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
   logic [31:0]                cyc_q, cyc_d;
   logic [2:0]                 err_q, err_d;
   logic                       irq_q, irq_d;

   // decode
   logic                  w_io, w_aligned, w_wr, w_rd, w_acc;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [15:0]           w_off;
   logic                  w_io_ok, w_mapped, w_unmapped, w_misalign;
   logic                  w_ram_we, w_push, w_pop, w_drop, w_enq;
   logic                  w_full, w_empty, w_cyc_ld;
   logic [2:0]            w_err_set, w_err_clr;
   logic [3:0]            w_cnt4;
   logic [31:0]           w_status;
   logic                  w_unused_ctl;

   assign w_unused_ctl = MEMReg_s5[3] ^ MEMReg_s5[0];

   assign w_io      = (DataAddr[31:16] == IO_PAGE);
   assign w_aligned = (DataAddr[1:0] == 2'b00);
   assign w_wr      = MEMReg_s5[1];
   assign w_rd      = MEMReg_s5[2] & ~MEMReg_s5[1];
   assign w_acc     = w_wr | w_rd;
   assign w_idx     = DataAddr[ADDR_WIDTH+1:2];
   assign w_off     = DataAddr[15:0];

   assign w_misalign = w_acc & ~w_aligned;
   assign w_io_ok    = w_io & w_aligned;
   assign w_mapped   = (w_off == c_OFF_CONSOLE) || (w_off == c_OFF_STATUS) ||
                       (w_off == c_OFF_CYCLE)   || (w_off == c_OFF_ERR);
   assign w_unmapped = w_io_ok & w_acc & ~w_mapped;

   assign w_ram_we = reset & w_wr & ~w_io & w_aligned;
   assign w_push   = w_wr & w_io_ok & (w_off == c_OFF_CONSOLE);
   assign w_cyc_ld = w_wr & w_io_ok & (w_off == c_OFF_CYCLE);

   assign w_full  = (count_q == c_CNT_FULL);
   assign w_empty = (count_q == '0);
   assign w_pop   = ~w_empty & out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_enq   = w_push & ~w_drop;

   assign w_err_set = {w_unmapped, w_drop, w_misalign};
   assign w_err_clr = (w_wr & w_io_ok & (w_off == c_OFF_ERR)) ? DataOut[2:0] : 3'b000;

   assign w_cnt4   = 4'(count_q);
   assign w_status = {24'b0, w_cnt4, 2'b00, w_full, w_empty};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_enq) begin
         wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      if (w_enq && !w_pop) begin
         count_d = count_q + c_CNT_ONE;
      end else if (!w_enq && w_pop) begin
         count_d = count_q - c_CNT_ONE;
      end
      cyc_d = w_cyc_ld ? DataOut : (cyc_q + 32'd1);
      // set wins over a simultaneous write-1-to-clear
      err_d = (err_q & ~w_err_clr) | w_err_set;
      irq_d = |err_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cyc_q    <= '0;
         err_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cyc_q    <= cyc_d;
         err_q    <= err_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         ram_q[w_idx] <= DataOut;
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         fifo_q[wr_ptr_q] <= DataOut;
      end
   end

   always_comb begin
      DataIn = '0;
      if (w_rd && w_aligned) begin
         if (!w_io) begin
            DataIn = ram_q[w_idx];
         end else begin
            case (w_off)
               c_OFF_STATUS: DataIn = w_status;
               c_OFF_CYCLE:  DataIn = cyc_q;
               c_OFF_ERR:    DataIn = {29'b0, err_q};
               default:      DataIn = '0;
            endcase
         end
      end
   end

   assign out_valid = ~w_empty;
   assign out_data  = w_empty ? 32'd0 : fifo_q[rd_ptr_q];
   assign irq_err   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_data_mem_responder.sv
`default_nettype none
// Bench for mips_data_mem_responder: directed checks plus randomized traffic
// compared every cycle against a queue/array reference model.
module tb_mips_data_mem_responder;

   localparam logic [3:0] c_IDLE = 4'b0000;
   localparam logic [3:0] c_WR   = 4'b0010;
   localparam logic [3:0] c_RD   = 4'b0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] dout = '0;
   logic [3:0]  ctl = '0;
   logic        rdy = 1'b0;
   logic [31:0] din, odata;
   logic        ovalid, irq;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_ram [256];
   logic [31:0] m_q [$];
   logic [31:0] m_cyc = '0;
   logic [2:0]  m_err = '0;

   mips_data_mem_responder #(.ADDR_WIDTH(8), .FIFO_DEPTH_LOG2(3), .IO_PAGE(16'hFFFF)) dut (
      .clk(clk), .reset(reset), .DataAddr(addr), .DataOut(dout), .MEMReg_s5(ctl),
      .DataIn(din), .out_data(odata), .out_valid(ovalid), .out_ready(rdy), .irq_err(irq));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_din();
      int sz = m_q.size();
      if (!(ctl[2] && !ctl[1]) || addr[1:0] != 2'b00) return 32'd0;
      if (addr[31:16] != 16'hFFFF) return m_ram[addr[9:2]];
      case (addr[15:0])
         16'h0004: return {24'b0, 4'(sz), 2'b00, sz == 8, sz == 0};
         16'h0008: return m_cyc;
         16'h000C: return {29'b0, m_err};
         default:  return 32'd0;
      endcase
   endfunction

   // Apply the inputs that the coming rising edge will sample.
   task automatic m_step();
      bit wr = ctl[1];
      bit rd = ctl[2] && !ctl[1];
      bit io = (addr[31:16] == 16'hFFFF);
      bit pop = (m_q.size() != 0) && rdy;
      bit push = 0;
      bit ld = 0;
      int sz = m_q.size();
      logic [2:0] set = '0;
      logic [2:0] clr = '0;
      if ((wr || rd) && addr[1:0] != 2'b00) set[0] = 1'b1;
      else if (wr && !io) m_ram[addr[9:2]] = dout;
      else if (io && (wr || rd)) begin
         case (addr[15:0])
            16'h0000: push = wr;
            16'h0004: ;
            16'h0008: ld = wr;
            16'h000C: if (wr) clr = dout[2:0];
            default:  set[2] = 1'b1;
         endcase
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (sz == 8 && !pop) set[1] = 1'b1;
         else m_q.push_back(dout);
      end
      m_cyc = ld ? dout : m_cyc + 32'd1;
      m_err = (m_err & ~clr) | set;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_q.delete();
            m_cyc = '0;
            m_err = '0;
         end
         chk("DataIn", din, m_din());
         chk("out_valid", {31'b0, ovalid}, {31'b0, m_q.size() != 0});
         chk("out_data", odata, (m_q.size() != 0) ? m_q[0] : 32'd0);
         chk("irq_err", {31'b0, irq}, {31'b0, |m_err});
         if (reset) m_step();
      end
   end

   task automatic op(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] c, input logic r);
      @(posedge clk);
      #1;
      addr = a; dout = d; ctl = c; rdy = r;
      #2;
   endtask

   initial begin
      logic [31:0] a;
      int k;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("reset out_valid", {31'b0, ovalid}, 32'd0);
      chk("reset out_data", odata, 32'd0);
      chk("reset irq_err", {31'b0, irq}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 256; i++) op(32'(i * 4), $urandom, c_WR, 1'b0);

      op(32'h0000_0010, 32'hDEADBEEF, c_WR, 1'b0);
      op(32'h0000_0010, 32'd0, c_RD, 1'b0);
      chk("ram read", din, 32'hDEADBEEF);
      op(32'h0000_0410, 32'd0, c_RD, 1'b0);
      chk("ram alias", din, 32'hDEADBEEF);

      op(32'h0000_0012, 32'h1234_5678, c_WR, 1'b0);
      op(32'hFFFF_000C, 32'd0, c_RD, 1'b0);
      chk("err misaligned", din, 32'd1);
      chk("irq misaligned", {31'b0, irq}, 32'd1);
      op(32'h0000_0010, 32'd0, c_RD, 1'b0);
      chk("ram untouched", din, 32'hDEADBEEF);
      op(32'hFFFF_000C, 32'd1, c_WR, 1'b0);
      op(32'hFFFF_000C, 32'd0, c_RD, 1'b0);
      chk("err cleared", din, 32'd0);
      chk("irq cleared", {31'b0, irq}, 32'd0);

      for (int i = 1; i <= 9; i++) op(32'hFFFF_0000, 32'(i), c_WR, 1'b0);
      op(32'hFFFF_0004, 32'd0, c_RD, 1'b0);
      chk("status full", din, 32'h82);
      chk("head after overflow", odata, 32'd1);
      op(32'hFFFF_000C, 32'd0, c_RD, 1'b0);
      chk("err overflow", din, 32'd2);
      op(32'hFFFF_000C, 32'd7, c_WR, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         op(32'd0, 32'd0, c_IDLE, 1'b1);
         chk("drain order", odata, 32'(i));
      end
      op(32'hFFFF_0004, 32'd0, c_RD, 1'b0);
      chk("status empty", din, 32'h01);
      chk("drained valid", {31'b0, ovalid}, 32'd0);

      for (int i = 0; i < 8; i++) op(32'hFFFF_0000, 32'h100 + 32'(i), c_WR, 1'b0);
      op(32'hFFFF_0000, 32'hAA, c_WR, 1'b1);
      chk("full head", odata, 32'h100);
      op(32'hFFFF_0004, 32'd0, c_RD, 1'b0);
      chk("status push+pop", din, 32'h82);
      op(32'hFFFF_000C, 32'd0, c_RD, 1'b0);
      chk("err push+pop", din, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         op(32'd0, 32'd0, c_IDLE, 1'b1);
         chk("drain after push+pop", odata, (i < 8) ? 32'h100 + 32'(i) : 32'hAA);
      end

      op(32'hFFFF_0008, 32'hFFFF_FFFE, c_WR, 1'b0);
      op(32'hFFFF_0008, 32'd0, c_RD, 1'b0);
      chk("cycle loaded", din, 32'hFFFF_FFFE);
      op(32'hFFFF_0008, 32'd0, c_RD, 1'b0);
      chk("cycle +1", din, 32'hFFFF_FFFF);
      op(32'hFFFF_0008, 32'd0, c_RD, 1'b0);
      chk("cycle wrap", din, 32'd0);

      for (int i = 1; i <= 3; i++) op(32'hFFFF_0000, 32'h200 + 32'(i), c_WR, 1'b0);
      op(32'd0, 32'd0, c_IDLE, 1'b1);
      chk("queued valid", {31'b0, ovalid}, 32'd1);
      reset = 1'b0;
      #1;
      chk("async reset valid", {31'b0, ovalid}, 32'd0);
      chk("async reset data", odata, 32'd0);
      rdy = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      op(32'h0000_0010, 32'd0, c_RD, 1'b0);
      chk("ram after reset", din, 32'hDEADBEEF);

      repeat (3000) begin
         k = $urandom % 10;
         if (k == 0)      a = $urandom & 32'hFFFE_FFFC;
         else if (k < 3)  a = $urandom & 32'h0000_0FFC;
         else if (k < 8)  a = {16'hFFFF, 16'(4 * ($urandom % 4))};
         else if (k == 8) a = {16'hFFFF, 16'($urandom % 64)};
         else             a = $urandom & 32'h0000_03FF;
         op(a, $urandom, 4'($urandom % 16), 1'($urandom % 2));
      end
      op(32'd0, 32'd0, c_IDLE, 1'b0);
      @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
